// File: rtl/hack_fetch_pkg.sv
// Shared widths, reset fetch address and the prefetch queue entry layout for the Hack fetch stage.
package hack_fetch_pkg;
    localparam int ADDR_W  = 15;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = '0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;
endpackage

// File: rtl/hack_fetch_unit_fifo.sv
// DEPTH-entry circular prefetch queue; 1-cycle write-to-head latency, head visible combinationally.
// Caller guarantees no push when full; flush empties the queue and drops any same-edge push/pop.
module fetch_fifo
    import hack_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  fetch_entry_t  push_dat,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);
    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= push_dat;
    end

    assign count = cnt_q;
    assign head  = mem_q[rd_q];
endmodule

// File: rtl/hack_fetch_unit.sv
// Hack instruction fetch: sequential ROM issue into a prefetch queue, valid/ready to decode, jmp redirect (3-cycle, 2 with FETCH_BYPASS_EN).
// Issue stalls when queue plus in-flight word would exceed DEPTH; instr_ready=0 holds the head.
module hack_fetch_unit
    import hack_fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_dout,
    input  logic               jmp,
    input  logic [ADDR_W-1:0]  jmp_target,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [CW-1:0]     count;
    fetch_entry_t      head, rsp;
    logic              issue, push, pop, q_nempty;

    assign rom_addr = fpc_q;
    assign q_nempty = (count != '0);
    assign rsp      = '{instr: rom_dout, pc: inflight_pc_q};

    // Counting the in-flight word reserves its slot, so a push is never refused.
    assign issue = !jmp && (({1'b0, count} + (CW+1)'(inflight_q)) < DEPTH_C);

`ifdef FETCH_BYPASS_EN
    logic byp;
    assign byp         = !q_nempty && inflight_q;
    assign instr_valid = q_nempty || byp;
    assign push        = inflight_q && !jmp && !(byp && instr_ready);
    assign pop         = q_nempty && instr_ready && !jmp;

    always_comb begin
        instr    = '0;
        instr_pc = '0;
        if (q_nempty) begin
            instr    = head.instr;
            instr_pc = head.pc;
        end else if (byp) begin
            instr    = rsp.instr;
            instr_pc = rsp.pc;
        end
    end
`else
    assign instr_valid = q_nempty;
    assign push        = inflight_q && !jmp;
    assign pop         = q_nempty && instr_ready && !jmp;

    always_comb begin
        instr    = '0;
        instr_pc = '0;
        if (q_nempty) begin
            instr    = head.instr;
            instr_pc = head.pc;
        end
    end
`endif

    always_comb begin
        fpc_d         = fpc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (jmp) begin
            fpc_d = jmp_target;
        end else if (issue) begin
            fpc_d         = fpc_q + 15'd1;
            inflight_d    = 1'b1;
            inflight_pc_d = fpc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q         <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (rsp),
        .pop      (pop),
        .flush    (jmp),
        .count    (count),
        .head     (head)
    );
endmodule

// File: tb/tb_hack_fetch_unit.sv
// Self-checking bench for hack_fetch_unit: directed scenarios with literal expectations plus random stalls/jumps against a queue model.
module tb_hack_fetch_unit;
    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
    localparam int LAT = 2;
`else
    localparam bit BYP = 1'b0;
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        jmp = 1'b0;
    logic [14:0] jmp_target = '0;
    logic        instr_ready = 1'b0;
    logic [15:0] rom_dout = '0;
    logic [14:0] rom_addr, instr_pc;
    logic [15:0] instr;
    logic        instr_valid;

    int checks = 0;
    int failures = 0;

    hack_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(15'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .rom_addr    (rom_addr),
        .rom_dout    (rom_dout),
        .jmp         (jmp),
        .jmp_target  (jmp_target),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_fn(input logic [14:0] a);
        case (a)
            15'd0:   rom_fn = 16'h0010;
            15'd1:   rom_fn = 16'h8C10;
            15'd2:   rom_fn = 16'h0011;
            15'd3:   rom_fn = 16'hE308;
            15'd4:   rom_fn = 16'h0012;
            15'd5:   rom_fn = 16'hFC10;
            default: rom_fn = 16'(a * 17'd40503) ^ 16'h3C5A;
        endcase
    endfunction

    // Synchronous-read ROM
    always @(posedge clk) rom_dout <= rom_fn(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of buffered pcs, one optional word in flight, fetch pointer.
    logic [14:0] mq[$];
    logic [14:0] m_fpc = '0;
    logic [14:0] m_inf_pc = '0;
    bit          m_inf = 1'b0;
    int          m_occ;
    bit          m_issue, m_take;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_fpc = '0;
            m_inf = 1'b0;
            m_inf_pc = '0;
        end else if (jmp) begin
            mq.delete();
            m_inf = 1'b0;
            m_fpc = jmp_target;
        end else begin
            m_occ   = mq.size() + int'(m_inf);
            m_issue = (m_occ < DEPTH);
            m_take  = BYP && (mq.size() == 0) && m_inf && instr_ready;
            if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
            if (m_inf && !m_take) mq.push_back(m_inf_pc);
            if (m_issue) begin
                m_inf_pc = m_fpc;
                m_fpc    = m_fpc + 15'd1;
                m_inf    = 1'b1;
            end else begin
                m_inf = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic        mv;
            logic [14:0] mpc;
            mv  = (mq.size() > 0) || (BYP && m_inf);
            mpc = (mq.size() > 0) ? mq[0] : m_inf_pc;
            chk("model_valid", {31'd0, instr_valid}, {31'd0, mv});
            chk("model_rom_addr", {17'd0, rom_addr}, {17'd0, m_fpc});
            if (mv && instr_valid) begin
                chk("model_pc", {17'd0, instr_pc}, {17'd0, mpc});
                chk("model_instr", {16'd0, instr}, {16'd0, rom_fn(mpc)});
            end
        end
    end

    task automatic wait_valid(output int n);
        n = 0;
        @(negedge clk);
        while (!instr_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input logic rdy);
        @(posedge clk); #1;
        reset = 1'b1;
        jmp = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        instr_ready = rdy;
    endtask

    logic [15:0] exp_instr [6] = '{16'h0010, 16'h8C10, 16'h0011, 16'hE308, 16'h0012, 16'hFC10};
    logic [14:0] wrap_pcs [4] = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};

    initial begin
        int n;
        #2;
        chk("reset_valid", {31'd0, instr_valid}, 32'd0);
        chk("reset_rom_addr", {17'd0, rom_addr}, 32'd0);
        chk("reset_instr", {16'd0, instr}, 32'd0);
        chk("reset_instr_pc", {17'd0, instr_pc}, 32'd0);

        // Cold start streaming
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        instr_ready = 1'b1;
        wait_valid(n);
        chk("t1_latency", n, LAT - 1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            chk("t1_valid", {31'd0, instr_valid}, 32'd1);
            chk("t1_pc", {17'd0, instr_pc}, i);
            chk("t1_instr", {16'd0, instr}, {16'd0, exp_instr[i]});
        end

        // Stall until full, then drain with no gap
        do_reset(1'b0);
        repeat (10) @(negedge clk);
        chk("t2_rom_addr_hold", {17'd0, rom_addr}, 32'd4);
        chk("t2_head_pc", {17'd0, instr_pc}, 32'd0);
        @(posedge clk); #1 instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_valid", {31'd0, instr_valid}, 32'd1);
            chk("t2_pc", {17'd0, instr_pc}, i);
        end

        // Redirect with 3 queued and 1 in flight
        do_reset(1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t3_fpc_before", {17'd0, rom_addr}, 32'd4);
        jmp = 1'b1;
        jmp_target = 15'h0100;
        @(posedge clk); #1;
        jmp = 1'b0;
        instr_ready = 1'b1;
        wait_valid(n);
        chk("t3_latency", n, LAT - 1);
        chk("t3_pc", {17'd0, instr_pc}, 32'h100);

        // Redirect while pop and push are both active
        repeat (3) @(posedge clk);
        #1;
        jmp = 1'b1;
        jmp_target = 15'h2000;
        @(posedge clk); #1;
        jmp = 1'b0;
        wait_valid(n);
        chk("t4_latency", n, LAT - 1);
        chk("t4_pc", {17'd0, instr_pc}, 32'h2000);

        // Address wrap
        @(posedge clk); #1;
        jmp = 1'b1;
        jmp_target = 15'h7FFE;
        @(posedge clk); #1;
        jmp = 1'b0;
        wait_valid(n);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("t5_valid", {31'd0, instr_valid}, 32'd1);
            chk("t5_pc", {17'd0, instr_pc}, {17'd0, wrap_pcs[i]});
        end

        // Asynchronous reset with the queue full
        @(posedge clk); #1 instr_ready = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("t6_full_valid", {31'd0, instr_valid}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t6_async_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_async_rom_addr", {17'd0, rom_addr}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        instr_ready = 1'b1;
        wait_valid(n);
        chk("t6_latency", n, LAT - 1);
        chk("t6_pc", {17'd0, instr_pc}, 32'd0);

        // Random stalls and jumps
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            instr_ready = ($urandom_range(0, 9) < 7);
            jmp = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                jmp_target = 15'h7FFC + 15'($urandom_range(0, 3));
            else
                jmp_target = 15'($urandom);
        end
        @(posedge clk); #1 jmp = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
